// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, instruction field slices, branch target
// arithmetic and the fetch FSM state encoding.
package cpu_pkg;

    localparam int unsigned CpuAddrW = 16;
    localparam int unsigned CpuDataW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StHalted
    } fetch_state_e;

    function automatic logic [1:0] instr_op(input logic [CpuDataW-1:0] instr);
        return instr[15:14];
    endfunction

    function automatic logic [2:0] instr_ra(input logic [CpuDataW-1:0] instr);
        return instr[13:11];
    endfunction

    function automatic logic [2:0] instr_rb(input logic [CpuDataW-1:0] instr);
        return instr[10:8];
    endfunction

    function automatic logic [3:0] instr_opcode(input logic [CpuDataW-1:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [7:0] instr_d8(input logic [CpuDataW-1:0] instr);
        return instr[7:0];
    endfunction

    // pc + 1 + sext(d8), modulo 2^CpuAddrW
    function automatic logic [CpuAddrW-1:0] branch_target(input logic [CpuAddrW-1:0] pc,
                                                          input logic [7:0]          d8);
        return pc + CpuAddrW'(1) + {{(CpuAddrW-8){d8[7]}}, d8};
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC adder: pc+1, or pc+1+sext(disp) when the branch is taken.
module pc_next #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              br_take_i,
    input  logic [7:0]        br_disp_i,
    output logic [ADDR_W-1:0] pc_next_o
);

    logic [ADDR_W-1:0] disp_ext;

    always_comb begin
        disp_ext  = br_take_i ? {{(ADDR_W-8){br_disp_i[7]}}, br_disp_i} : '0;
        pc_next_o = pc_i + ADDR_W'(1) + disp_ext;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, memory read handshake with
// ack timeout, PC update and halt handling for the multicycle controller.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W      = CpuAddrW,
    parameter int unsigned       DATA_W      = CpuDataW,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              pc_upd,
    input  logic              br_take,
    input  logic [7:0]        br_disp,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] meirei,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_done,
    output logic              busy,
    output logic              err
);

    localparam logic [7:0] AckTimeout = 8'(ACK_TIMEOUT);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] meirei_q;
    logic [7:0]        cnt_q;
    logic              mem_rd_q;
    logic              fetch_done_q;
    logic              busy_q;
    logic              err_q;
    logic              halt_pend_q;
    logic [ADDR_W-1:0] pc_nxt;

    pc_next #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .pc_i     (pc_q),
        .br_take_i(br_take),
        .br_disp_i(br_disp),
        .pc_next_o(pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            mem_addr_q   <= '0;
            meirei_q     <= '0;
            cnt_q        <= '0;
            mem_rd_q     <= 1'b0;
            fetch_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            halt_pend_q  <= 1'b0;
        end else begin
            fetch_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (halt) begin
                        state_q <= StHalted;
                        busy_q  <= 1'b1;
                    end else if (pc_upd) begin
                        // PC update wins a collision; the dropped request is flagged
                        pc_q <= pc_nxt;
                        if (fetch_req) err_q <= 1'b1;
                    end else if (fetch_req) begin
                        state_q     <= StReq;
                        mem_addr_q  <= pc_q;
                        mem_rd_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        halt_pend_q <= 1'b0;
                    end
                end
                StReq: begin
                    if (pc_upd || fetch_req) err_q <= 1'b1;
                    if (mem_ack) begin
                        meirei_q <= mem_rdata;
                        mem_rd_q <= 1'b0;
                        if (halt_pend_q || halt) begin
                            state_q <= StHalted;
                        end else begin
                            state_q      <= StDone;
                            fetch_done_q <= 1'b1;
                        end
                    end else if (cnt_q == AckTimeout - 8'd1) begin
                        cnt_q    <= cnt_q + 8'd1;
                        mem_rd_q <= 1'b0;
                        err_q    <= 1'b1;
                        if (halt_pend_q || halt) begin
                            state_q <= StHalted;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (halt) halt_pend_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (pc_upd || fetch_req) err_q <= 1'b1;
                    if (halt) begin
                        state_q <= StHalted;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StHalted: begin
                    if (pc_upd || fetch_req) err_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign meirei     = meirei_q;
    assign pc         = pc_q;
    assign fetch_done = fetch_done_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized phase
// checked against a transaction-level model (latency counts, PC arithmetic).
module tb_fetch_unit;

    localparam int unsigned T = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic        pc_upd = 1'b0;
    logic        br_take = 1'b0;
    logic [7:0]  br_disp = 8'h00;
    logic        halt = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [15:0] meirei;
    logic [15:0] pc;
    logic        fetch_done;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic        m_err;

    fetch_unit #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .RESET_PC   (16'h0000),
        .ACK_TIMEOUT(T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .pc_upd    (pc_upd),
        .br_take   (br_take),
        .br_disp   (br_disp),
        .halt      (halt),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .meirei    (meirei),
        .pc        (pc),
        .fetch_done(fetch_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_pc  = 16'h0000;
        m_ir  = 16'h0000;
        m_err = 1'b0;
    endtask

    task automatic do_pc_upd(input logic take, input logic [7:0] disp, input string tag);
        int d;
        pc_upd  = 1'b1;
        br_take = take;
        br_disp = disp;
        step();
        pc_upd  = 1'b0;
        br_take = 1'b0;
        d = take ? int'($signed(disp)) : 0;
        m_pc = 16'(int'(m_pc) + 1 + d);
        check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    endtask

    // Fetch whose ack arrives after lat cycles without ack (lat >= T means it times out).
    task automatic do_fetch(input int lat, input logic [15:0] data, input string tag);
        int rd_cyc;
        int done_cyc;
        bit addr_ok;
        bit ok;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        rd_cyc   = 0;
        done_cyc = 0;
        addr_ok  = 1'b1;
        for (int c = 0; c < int'(T) + 4; c++) begin
            if (mem_rd === 1'b1) begin
                rd_cyc++;
                if (mem_addr !== m_pc) addr_ok = 1'b0;
            end
            if (fetch_done === 1'b1) done_cyc++;
            mem_ack   = (c == lat);
            mem_rdata = (c == lat) ? data : 16'($urandom);
            step();
        end
        mem_ack = 1'b0;
        ok = (lat <= int'(T) - 1);
        if (ok) m_ir = data;
        else m_err = 1'b1;
        check({tag, ".rd_cycles"}, 32'(rd_cyc), ok ? 32'(lat + 1) : 32'(T));
        check({tag, ".addr_stable"}, 32'(addr_ok), 32'd1);
        check({tag, ".done_pulses"}, 32'(done_cyc), ok ? 32'd1 : 32'd0);
        check({tag, ".meirei"}, 32'(meirei), 32'(m_ir));
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst.pc", 32'(pc), 32'h0000);
        check("rst.meirei", 32'(meirei), 32'h0000);
        check("rst.mem_addr", 32'(mem_addr), 32'h0000);
        check("rst.mem_rd", 32'(mem_rd), 32'd0);
        check("rst.fetch_done", 32'(fetch_done), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.err", 32'(err), 32'd0);

        // Minimum-latency fetch, cycle by cycle
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("min.c2.mem_rd", 32'(mem_rd), 32'd1);
        check("min.c2.mem_addr", 32'(mem_addr), 32'h0000);
        check("min.c2.busy", 32'(busy), 32'd1);
        check("min.c2.fetch_done", 32'(fetch_done), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hC010;
        step();
        mem_ack = 1'b0;
        check("min.c3.fetch_done", 32'(fetch_done), 32'd1);
        check("min.c3.meirei", 32'(meirei), 32'hC010);
        check("min.c3.mem_rd", 32'(mem_rd), 32'd0);
        step();
        check("min.c4.fetch_done", 32'(fetch_done), 32'd0);
        check("min.c4.busy", 32'(busy), 32'd0);
        check("min.c4.pc", 32'(pc), 32'h0000);
        m_ir = 16'hC010;

        // Sequential and branch PC updates, including wrap-around
        for (int i = 0; i < 5; i++) do_pc_upd(1'b0, 8'h00, "seq.walk");
        check("seq.at5", 32'(pc), 32'h0005);
        do_pc_upd(1'b0, 8'h00, "seq.5to6");
        check("seq.is6", 32'(pc), 32'h0006);
        do_reset();
        do_pc_upd(1'b1, 8'hFE, "br.0_minus2");
        check("br.wrap_ffff", 32'(pc), 32'hFFFF);
        do_pc_upd(1'b0, 8'h00, "seq.ffff");
        check("seq.wrap_0000", 32'(pc), 32'h0000);
        do_pc_upd(1'b1, 8'h0F, "br.to10");
        do_pc_upd(1'b1, 8'hFE, "br.fe");
        check("br.fe_is_000f", 32'(pc), 32'h000F);
        do_pc_upd(1'b1, 8'h00, "br.zero");
        do_pc_upd(1'b1, 8'h7F, "br.7f");
        check("br.7f_is_0090", 32'(pc), 32'h0090);

        // Wait states, ack exactly on the timeout edge, then a real timeout
        do_fetch(5, 16'h1234, "wait5");
        do_fetch(int'(T) - 1, 16'h5A5A, "ack_at_timeout");
        do_fetch(int'(T) + 2, 16'hDEAD, "timeout");

        // fetch_req and pc_upd together in IDLE
        do_reset();
        fetch_req = 1'b1;
        pc_upd    = 1'b1;
        step();
        fetch_req = 1'b0;
        pc_upd    = 1'b0;
        check("collide.pc", 32'(pc), 32'h0001);
        check("collide.err", 32'(err), 32'd1);
        check("collide.mem_rd", 32'(mem_rd), 32'd0);

        // pc_upd during REQ
        do_reset();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        pc_upd    = 1'b1;
        step();
        pc_upd = 1'b0;
        check("req_upd.pc", 32'(pc), 32'h0000);
        check("req_upd.err", 32'(err), 32'd1);
        check("req_upd.mem_rd", 32'(mem_rd), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();

        // halt during REQ: fetch completes silently, then frozen
        do_reset();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        halt      = 1'b1;
        step();
        halt      = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hABCD;
        step();
        mem_ack = 1'b0;
        check("halt.meirei", 32'(meirei), 32'hABCD);
        check("halt.fetch_done0", 32'(fetch_done), 32'd0);
        check("halt.busy", 32'(busy), 32'd1);
        check("halt.mem_rd", 32'(mem_rd), 32'd0);
        step();
        check("halt.fetch_done1", 32'(fetch_done), 32'd0);
        check("halt.err_before", 32'(err), 32'd0);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        check("halt.req_ignored", 32'(mem_rd), 32'd0);
        check("halt.busy_held", 32'(busy), 32'd1);
        check("halt.err_after", 32'(err), 32'd1);

        // Reset in the middle of a fetch; the late ack is ignored
        do_reset();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("rstmid.mem_rd_pre", 32'(mem_rd), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid.mem_rd", 32'(mem_rd), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        check("rstmid.meirei", 32'(meirei), 32'h0000);
        check("rstmid.fetch_done", 32'(fetch_done), 32'd0);
        check("rstmid.pc", 32'(pc), 32'h0000);
        check("rstmid.err", 32'(err), 32'd0);
        step();
        check("rstmid.fetch_done2", 32'(fetch_done), 32'd0);

        // Randomized mix of PC updates and fetches with varying ack latency
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_pc_upd(1'($urandom_range(0, 1)), 8'($urandom), "rnd.upd");
            end else if ($urandom_range(0, 9) < 8) begin
                do_fetch(int'($urandom_range(0, 6)), 16'($urandom), "rnd.fetch");
            end else begin
                do_fetch(int'($urandom_range(T - 3, T + 2)), 16'($urandom), "rnd.slow");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
